// File: rtl/local_predictor_bank.sv
// local_predictor_bank
//
// Four tables of 2-bit saturating direction counters, one table per 2-bit
// history value from ghr (00 UU, 01 UT, 10 TU, 11 TT). Fetch reads the entry
// picked by the current history and the fetch PC. Execute trains the entry
// picked by the history and PC that the resolving branch carried down.
//
// Ports:
//   clk_i            clock, rising edge
//   reset_ni         asynchronous active-low reset; all counters -> 01
//   local_src_i      current history, selects the Fetch read table
//   pc_f_i           Fetch PC
//   pc_src_pred_f_o  predicted direction for pc_f_i (1 = taken)
//   stall_e_i        Execute stall, blocks training
//   branch_op_e_i    Execute branch op, bit 0 = conditional branch
//   pc_src_res_e_i   resolved direction (1 = taken)
//   local_src_e_i    history captured at prediction time
//   pc_e_i           Execute PC of the resolving branch
module local_predictor_bank #(
  parameter int unsigned INDEX_WIDTH = 5
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic [1:0]  local_src_i,
  input  logic [31:0] pc_f_i,
  output logic        pc_src_pred_f_o,
  input  logic        stall_e_i,
  input  logic [1:0]  branch_op_e_i,
  input  logic        pc_src_res_e_i,
  input  logic [1:0]  local_src_e_i,
  input  logic [31:0] pc_e_i
);

  localparam int unsigned Entries = 1 << INDEX_WIDTH;

  logic [INDEX_WIDTH-1:0] w_idx_f;
  logic [INDEX_WIDTH-1:0] w_idx_e;
  logic                   w_train;
  logic [1:0]             w_cur_e;
  logic [1:0]             w_next_e;
  logic [1:0]             w_ctr [4][Entries];

  // Word-aligned index; upper PC bits are dropped, so aliasing is expected.
  assign w_idx_f = pc_f_i[INDEX_WIDTH+1:2];
  assign w_idx_e = pc_e_i[INDEX_WIDTH+1:2];

  assign w_train = branch_op_e_i[0] & ~stall_e_i;

  // No bypass: a same-cycle read of the trained entry sees the old value.
  assign pc_src_pred_f_o = w_ctr[local_src_i][w_idx_f][1];

  assign w_cur_e = w_ctr[local_src_e_i][w_idx_e];

  always_comb begin
    w_next_e = w_cur_e;
    if (pc_src_res_e_i) begin
      if (w_cur_e != 2'b11) w_next_e = w_cur_e + 2'd1;
    end else begin
      if (w_cur_e != 2'b00) w_next_e = w_cur_e - 2'd1;
    end
  end

  // One register per counter so reset can clear every entry asynchronously
  // and each entry has a single driver with a decoded write enable.
  for (genvar t = 0; t < 4; t++) begin : g_table
    for (genvar e = 0; e < Entries; e++) begin : g_entry
      logic [1:0] r_ctr;
      logic       w_we;

      assign w_we = w_train && (local_src_e_i == 2'(t)) &&
                    (w_idx_e == INDEX_WIDTH'(e));

      always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
          r_ctr <= 2'b01;
        end else if (w_we) begin
          r_ctr <= w_next_e;
        end
      end

      assign w_ctr[t][e] = r_ctr;
    end
  end

endmodule

// File: tb/tb_local_predictor_bank.sv
module tb_local_predictor_bank;

  logic        clk;
  logic        reset_n;
  logic [1:0]  local_src;
  logic [31:0] pc_f;
  logic        pred;
  logic        stall_e;
  logic [1:0]  branch_op_e;
  logic        res_e;
  logic [1:0]  local_src_e;
  logic [31:0] pc_e;

  int total;
  int bad;

  local_predictor_bank #(.INDEX_WIDTH(5)) dut (
    .clk_i           (clk),
    .reset_ni        (reset_n),
    .local_src_i     (local_src),
    .pc_f_i          (pc_f),
    .pc_src_pred_f_o (pred),
    .stall_e_i       (stall_e),
    .branch_op_e_i   (branch_op_e),
    .pc_src_res_e_i  (res_e),
    .local_src_e_i   (local_src_e),
    .pc_e_i          (pc_e)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  ls;
    logic [31:0] pcf;
    logic        stall;
    logic [1:0]  bop;
    logic        res;
    logic [1:0]  lse;
    logic [31:0] pce;
    logic        exp;
  } vec_t;

  vec_t vecs[$];

  // Reference model: counters as integers 0..3, taken when >= 2.
  int model [4][32];

  function automatic int idx_of(logic [31:0] pc);
    return int'((pc >> 2) % 32);
  endfunction

  function automatic void model_reset();
    for (int t = 0; t < 4; t++)
      for (int e = 0; e < 32; e++) model[t][e] = 1;
  endfunction

  function automatic void model_train(logic [1:0] bop, logic stall, logic res,
                                      logic [1:0] lse, logic [31:0] pce);
    int v;
    if (bop[0] && !stall) begin
      v = model[lse][idx_of(pce)];
      v = res ? v + 1 : v - 1;
      if (v > 3) v = 3;
      if (v < 0) v = 0;
      model[lse][idx_of(pce)] = v;
    end
  endfunction

  function automatic logic model_pred(logic [1:0] ls, logic [31:0] pcf);
    return model[ls][idx_of(pcf)] >= 2;
  endfunction

  function automatic void add(logic [1:0] ls, logic [31:0] pcf, logic stall,
                              logic [1:0] bop, logic res, logic [1:0] lse,
                              logic [31:0] pce, logic exp);
    vec_t v;
    v.ls = ls; v.pcf = pcf; v.stall = stall; v.bop = bop; v.res = res;
    v.lse = lse; v.pce = pce; v.exp = exp;
    vecs.push_back(v);
  endfunction

  task automatic check(string nm, logic act, logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    stall_e = 1'b0; branch_op_e = 2'b00; res_e = 1'b0;
    local_src_e = 2'b00; pc_e = 32'h0;
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset_n = 1'b0;
    local_src = 2'b00;
    pc_f = 32'h0;
    idle_inputs();

    // Training rows: inputs held for one cycle, exp is the pre-edge read.
    // Saturation on table 01 at 0x40.
    add(2'b01, 32'h40, 0, 2'b01, 1, 2'b01, 32'h40, 0); // 01->10, same-cycle read old
    add(2'b01, 32'h40, 0, 2'b01, 1, 2'b01, 32'h40, 1); // 10->11
    add(2'b01, 32'h40, 0, 2'b01, 1, 2'b01, 32'h40, 1);
    add(2'b01, 32'h40, 0, 2'b01, 1, 2'b01, 32'h40, 1);
    add(2'b01, 32'h40, 0, 2'b01, 0, 2'b01, 32'h40, 1); // 11->10
    add(2'b01, 32'h40, 0, 2'b01, 0, 2'b01, 32'h40, 1); // 10->01
    add(2'b01, 32'h40, 0, 2'b01, 0, 2'b01, 32'h40, 0); // 01->00
    add(2'b01, 32'h40, 0, 2'b01, 0, 2'b01, 32'h40, 0);
    add(2'b01, 32'h40, 0, 2'b00, 0, 2'b01, 32'h40, 0);
    // Table isolation: table 11 at 0x40.
    add(2'b11, 32'h40, 0, 2'b01, 1, 2'b11, 32'h40, 0);
    add(2'b11, 32'h40, 0, 2'b01, 1, 2'b11, 32'h40, 1);
    add(2'b11, 32'h40, 0, 2'b00, 0, 2'b00, 32'h0, 1);
    add(2'b00, 32'h40, 0, 2'b00, 0, 2'b00, 32'h0, 0);
    add(2'b01, 32'h40, 0, 2'b00, 0, 2'b00, 32'h0, 0);
    add(2'b10, 32'h40, 0, 2'b00, 0, 2'b00, 32'h0, 0);
    // Index isolation / aliasing: table 00 at 0x40.
    add(2'b00, 32'h40, 0, 2'b01, 1, 2'b00, 32'h40, 0);
    add(2'b00, 32'h40, 0, 2'b01, 1, 2'b00, 32'h40, 1);
    add(2'b00, 32'h44, 0, 2'b00, 0, 2'b00, 32'h0, 0);
    add(2'b00, 32'hC0, 0, 2'b00, 0, 2'b00, 32'h0, 1);
    add(2'b00, 32'h42, 0, 2'b00, 0, 2'b00, 32'h0, 1);
    // Enable: branch_op 00 / 10 never trains (table 10, 0x80).
    for (int i = 0; i < 4; i++) add(2'b10, 32'h80, 0, 2'b00, 1, 2'b10, 32'h80, 0);
    for (int i = 0; i < 4; i++) add(2'b10, 32'h80, 0, 2'b10, 1, 2'b10, 32'h80, 0);
    // Stall: 5 stalled edges, then one unstalled edge trains exactly once.
    for (int i = 0; i < 5; i++) add(2'b10, 32'h80, 1, 2'b01, 1, 2'b10, 32'h80, 0);
    add(2'b10, 32'h80, 0, 2'b01, 1, 2'b10, 32'h80, 0); // 01->10
    add(2'b10, 32'h80, 0, 2'b01, 0, 2'b10, 32'h80, 1); // 10->01 (proves single step)
    add(2'b10, 32'h80, 0, 2'b00, 0, 2'b00, 32'h0, 0);

    // Reset held two cycles, checked while asserted and after release.
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 check("reset_held", pred, 1'b0);
    reset_n = 1'b1;
    for (int t = 0; t < 4; t++) begin
      for (int p = 0; p < 32; p++) begin
        local_src = 2'(t);
        pc_f = 32'(p * 4);
        #0.1;
        check($sformatf("reset_t%0d_pc%0h", t, p * 4), pred, 1'b0);
      end
    end

    // Directed table.
    foreach (vecs[i]) begin
      @(negedge clk);
      local_src = vecs[i].ls; pc_f = vecs[i].pcf; stall_e = vecs[i].stall;
      branch_op_e = vecs[i].bop; res_e = vecs[i].res;
      local_src_e = vecs[i].lse; pc_e = vecs[i].pce;
      #2 check($sformatf("vec%0d", i), pred, vecs[i].exp);
      @(posedge clk);
    end

    // Async reset mid-operation: table 00 @0x40 is strongly taken here.
    @(negedge clk);
    idle_inputs();
    local_src = 2'b00; pc_f = 32'h40;
    #1 check("pre_async_reset", pred, 1'b1);
    #1 reset_n = 1'b0;
    #1 check("async_reset_drop", pred, 1'b0);
    // Training during reset is lost.
    branch_op_e = 2'b01; res_e = 1'b1; local_src_e = 2'b00; pc_e = 32'h40;
    @(posedge clk);
    @(negedge clk);
    idle_inputs();
    reset_n = 1'b1;
    #1 check("update_in_reset_lost", pred, 1'b0);
    // First edge after release trains.
    branch_op_e = 2'b01; res_e = 1'b1; local_src_e = 2'b00; pc_e = 32'h40;
    @(posedge clk);
    #1 check("first_edge_trains", pred, 1'b1);

    // Randomized run against the model, starting from a fresh reset.
    @(negedge clk);
    idle_inputs();
    reset_n = 1'b0;
    #1 reset_n = 1'b1;
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      logic exp;
      @(negedge clk);
      local_src   = 2'($urandom);
      pc_f        = $urandom & 32'h0000_00FF;
      stall_e     = ($urandom_range(0, 3) == 0);
      branch_op_e = 2'($urandom);
      res_e       = ($urandom_range(0, 2) != 0);
      local_src_e = 2'($urandom);
      pc_e        = $urandom;
      if (c % 4 == 0) begin
        local_src_e = local_src;
        pc_e = pc_f;
      end
      exp = model_pred(local_src, pc_f);
      #2 check($sformatf("rand%0d", c), pred, exp);
      @(posedge clk);
      model_train(branch_op_e, stall_e, res_e, local_src_e, pc_e);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

endmodule
